// File: rtl/sbox_session_controller.sv
// Session sequencer for a chaos-seeded S-box generator: seeds, warms up,
// generates with a timeout, and reports done/error with a success count.
module sbox_session_controller #(
    parameter int WARMUP  = 64,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] seed_x1,
    input  logic [31:0] seed_x2,
    input  logic [31:0] seed_x3,
    input  logic        sbox_ready,
    output logic        chaos_reset,
    output logic [31:0] chaos_x1_init,
    output logic [31:0] chaos_x2_init,
    output logic [31:0] chaos_x3_init,
    output logic        sbox_reset,
    output logic        sbox_enable_bar,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  gen_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_WARMUP,
        S_GEN,
        S_DONE,
        S_ERROR
    } state_t;

    localparam bit          WARM_NONE = (WARMUP == 0);
    localparam logic [15:0] WARM_LAST = 16'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    // {chaos_reset, sbox_reset, sbox_enable_bar, busy, done, error}
    localparam logic [5:0] OUT_RST = 6'b111_000;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
    logic [7:0]  gen_q, gen_d;
    logic [5:0]  out_q, out_d;
    logic        accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        x3_d    = x3_q;
        gen_d   = gen_q;
        accept  = 1'b0;
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        accept  = 1'b1;
                        state_d = S_SEED;
                    end
                end
                S_SEED: begin
                    cnt_d   = '0;
                    state_d = WARM_NONE ? S_GEN : S_WARMUP;
                end
                S_WARMUP: begin
                    if (cnt_q == WARM_LAST) begin
                        state_d = S_GEN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_GEN: begin
                    // ready beats a timeout landing on the same edge
                    if (sbox_ready) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        if (gen_q != 8'hff) gen_d = gen_q + 8'd1;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = S_ERROR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (accept) begin
            x1_d = seed_x1;
            x2_d = seed_x2;
            x3_d = seed_x3;
        end
    end

    // Outputs are registered, decoded from the state being entered
    always_comb begin
        case (state_d)
            S_IDLE:   out_d = OUT_RST;
            S_SEED:   out_d = 6'b111_100;
            S_WARMUP: out_d = 6'b011_100;
            S_GEN:    out_d = 6'b000_100;
            S_DONE:   out_d = 6'b101_010;
            S_ERROR:  out_d = 6'b111_001;
            default:  out_d = OUT_RST;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            x3_q    <= '0;
            gen_q   <= '0;
            out_q   <= OUT_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            x3_q    <= x3_d;
            gen_q   <= gen_d;
            out_q   <= out_d;
        end
    end

    assign chaos_reset     = out_q[5];
    assign sbox_reset      = out_q[4];
    assign sbox_enable_bar = out_q[3];
    assign busy            = out_q[2];
    assign done            = out_q[1];
    assign error           = out_q[0];
    assign chaos_x1_init   = x1_q;
    assign chaos_x2_init   = x2_q;
    assign chaos_x3_init   = x3_q;
    assign gen_count       = gen_q;

endmodule

// File: tb/tb_sbox_session_controller.sv
// Scoreboard bench: two builds (WARMUP=4 and WARMUP=0, TIMEOUT=16) share
// stimulus; a phase/countdown reference model predicts every edge.
module tb_sbox_session_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        sbox_ready = 1'b0;
    logic [31:0] seed_x1 = '0, seed_x2 = '0, seed_x3 = '0;

    logic        cr_a, sr_a, eb_a, busy_a, done_a, err_a;
    logic [31:0] x1_a, x2_a, x3_a;
    logic [7:0]  cnt_a;
    logic        cr_b, sr_b, eb_b, busy_b, done_b, err_b;
    logic [31:0] x1_b, x2_b, x3_b;
    logic [7:0]  cnt_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sbox_session_controller #(.WARMUP(4), .TIMEOUT(16)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .seed_x1(seed_x1), .seed_x2(seed_x2), .seed_x3(seed_x3),
        .sbox_ready(sbox_ready), .chaos_reset(cr_a),
        .chaos_x1_init(x1_a), .chaos_x2_init(x2_a), .chaos_x3_init(x3_a),
        .sbox_reset(sr_a), .sbox_enable_bar(eb_a), .busy(busy_a),
        .done(done_a), .error(err_a), .gen_count(cnt_a)
    );

    sbox_session_controller #(.WARMUP(0), .TIMEOUT(16)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .seed_x1(seed_x1), .seed_x2(seed_x2), .seed_x3(seed_x3),
        .sbox_ready(sbox_ready), .chaos_reset(cr_b),
        .chaos_x1_init(x1_b), .chaos_x2_init(x2_b), .chaos_x3_init(x3_b),
        .sbox_reset(sr_b), .sbox_enable_bar(eb_b), .busy(busy_b),
        .done(done_b), .error(err_b), .gen_count(cnt_b)
    );

    typedef enum {M_IDLE, M_SEED, M_WARM, M_GEN, M_DONE, M_ERR} mode_e;
    typedef struct {
        mode_e       mode;
        int          left;
        logic [31:0] x1, x2, x3;
        int          gens;
    } model_t;

    model_t ma, mb;
    logic [109:0] qa[$];
    logic [109:0] qb[$];

    function automatic model_t cleared();
        model_t n;
        n.mode = M_IDLE;
        n.left = 0;
        n.x1 = '0;
        n.x2 = '0;
        n.x3 = '0;
        n.gens = 0;
        return n;
    endfunction

    // One rising edge of a session: left counts cycles remaining in a phase
    function automatic model_t step(model_t m, int w, int t);
        model_t n = m;
        if (reset) return cleared();
        if (abort && m.mode != M_IDLE) begin
            n.mode = M_IDLE;
            return n;
        end
        case (m.mode)
            M_IDLE, M_DONE, M_ERR: if (start) begin
                n.mode = M_SEED;
                n.x1 = seed_x1;
                n.x2 = seed_x2;
                n.x3 = seed_x3;
            end
            M_SEED: begin
                n.mode = (w > 0) ? M_WARM : M_GEN;
                n.left = (w > 0) ? w : t;
            end
            M_WARM: begin
                n.left = m.left - 1;
                if (n.left == 0) begin
                    n.mode = M_GEN;
                    n.left = t;
                end
            end
            M_GEN: begin
                if (sbox_ready) begin
                    n.mode = M_DONE;
                    n.gens = (m.gens < 255) ? m.gens + 1 : 255;
                end else begin
                    n.left = m.left - 1;
                    if (n.left == 0) n.mode = M_ERR;
                end
            end
            default: n.mode = M_IDLE;
        endcase
        return n;
    endfunction

    function automatic logic [109:0] expect_of(model_t m);
        logic [5:0] f;
        case (m.mode)
            M_IDLE:  f = 6'b111_000;
            M_SEED:  f = 6'b111_100;
            M_WARM:  f = 6'b011_100;
            M_GEN:   f = 6'b000_100;
            M_DONE:  f = 6'b101_010;
            default: f = 6'b111_001;
        endcase
        return {f, 8'(m.gens), m.x1, m.x2, m.x3};
    endfunction

    task automatic push_both();
        qa.push_back(expect_of(ma));
        qb.push_back(expect_of(mb));
    endtask

    task automatic cycle();
        ma = step(ma, 4, 16);
        mb = step(mb, 0, 16);
        push_both();
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2;
        ma = cleared();
        mb = cleared();
        push_both();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic new_seeds();
        seed_x1 = $urandom;
        seed_x2 = $urandom;
        seed_x3 = $urandom;
    endtask

    // Monitor: every clock edge or reset assertion yields one observation
    initial begin
        logic [109:0] act, exp_v;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            act = {cr_a, sr_a, eb_a, busy_a, done_a, err_a, cnt_a,
                   x1_a, x2_a, x3_a};
            tests++;
            if (qa.size() == 0) begin
                fails++;
                $display("FAIL w4_queue_empty at %0t", $time);
            end else begin
                exp_v = qa.pop_front();
                if (act !== exp_v) begin
                    fails++;
                    $display("FAIL w4_outputs at %0t got %h exp %h",
                             $time, act, exp_v);
                end
            end
            act = {cr_b, sr_b, eb_b, busy_b, done_b, err_b, cnt_b,
                   x1_b, x2_b, x3_b};
            tests++;
            if (qb.size() == 0) begin
                fails++;
                $display("FAIL w0_queue_empty at %0t", $time);
            end else begin
                exp_v = qb.pop_front();
                if (act !== exp_v) begin
                    fails++;
                    $display("FAIL w0_outputs at %0t got %h exp %h",
                             $time, act, exp_v);
                end
            end
        end
    end

    initial begin
        #1;
        ma = cleared();
        mb = cleared();
        push_both();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Nominal session, ready after 10 GENERATE cycles
        seed_x1 = 32'h3DCCCD53;
        seed_x2 = 32'h3C23D70A;
        seed_x3 = 32'h00000000;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        repeat (10) cycle();
        sbox_ready = 1'b1;
        cycle();
        sbox_ready = 1'b0;
        repeat (2) cycle();

        // Timeout, then rekey out of ERROR
        new_seeds();
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (24) cycle();
        new_seeds();
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();

        // Ready on the last GENERATE cycle of the WARMUP=4 build
        repeat (4) cycle();
        repeat (15) cycle();
        sbox_ready = 1'b1;
        cycle();
        sbox_ready = 1'b0;
        cycle();

        // Busy start ignored, then abort+start during warmup
        new_seeds();
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        new_seeds();
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        new_seeds();
        abort = 1'b1;
        start = 1'b1;
        cycle();
        abort = 1'b0;
        start = 1'b0;
        repeat (2) cycle();

        // Reset between edges in GENERATE
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (8) cycle();
        async_reset();
        repeat (3) cycle();

        // Saturate the success counter
        for (int s = 0; s < 260; s++) begin
            new_seeds();
            start = 1'b1;
            cycle();
            start = 1'b0;
            sbox_ready = 1'b1;
            repeat (6) cycle();
            sbox_ready = 1'b0;
        end
        cycle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            new_seeds();
            start = ($urandom % 8) == 0;
            abort = ($urandom % 64) == 0;
            sbox_ready = ($urandom % 10) == 0;
            if (($urandom % 500) == 0) async_reset();
            else cycle();
        end
        start = 1'b0;
        abort = 1'b0;
        sbox_ready = 1'b0;
        cycle();

        tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            fails++;
            $display("FAIL leftover_expect got %0d/%0d exp 0/0",
                     qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sbox_session_controller.md
SBOX_SESSION_CONTROLLER -- requirements
Module: sbox_session_controller

Interface
REQ-001 Parameter WARMUP, default 64: chaos-generator iterations discarded after seeding before S-box generation is enabled; legal range 0..65535.
REQ-002 Parameter TIMEOUT, default 4096: maximum cycles allowed in GENERATE for sbox_ready to rise; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a new S-box session using the seed inputs.
REQ-006 abort  input  1  cancel the current session and return to IDLE.
REQ-007 seed_x1, seed_x2, seed_x3  input  32 each  IEEE-754 single-precision chaos initial conditions.
REQ-008 sbox_ready  input  1  ready output of the S-box generator.
REQ-009 chaos_reset  output  1  reset to the chaos generator; it loads its initial values while high.
REQ-010 chaos_x1_init, chaos_x2_init, chaos_x3_init  output  32 each  latched seeds to the chaos generator.
REQ-011 sbox_reset  output  1  reset to the S-box generator.
REQ-012 sbox_enable_bar  output  1  active-low enable to the S-box generator.
REQ-013 busy, done, error  output  1 each  session status.
REQ-014 gen_count  output  8  number of successful sessions, saturating.

Function
REQ-015 The FSM SHALL have states IDLE, SEED, WARMUP, GENERATE, DONE and ERROR.
REQ-016 IDLE: chaos_reset=1, sbox_reset=1, sbox_enable_bar=1, busy=0; start high SHALL latch seed_x1..x3 into chaos_x*_init and move to SEED.
REQ-017 SEED SHALL last exactly one cycle with chaos_reset=1 and sbox_reset=1; next state is WARMUP, or GENERATE when WARMUP=0; the cycle counter SHALL clear.
REQ-018 WARMUP: chaos_reset=0, sbox_reset=1, sbox_enable_bar=1; the counter increments each cycle; the transition to GENERATE SHALL occur on the edge where the counter equals WARMUP-1, giving exactly WARMUP cycles in WARMUP; the counter then clears.
REQ-019 GENERATE: chaos_reset=0, sbox_reset=0, sbox_enable_bar=0; sbox_ready sampled high SHALL move to DONE; otherwise, on the edge where the counter equals TIMEOUT-1, the FSM SHALL move to ERROR.
REQ-020 sbox_ready high on the same edge that the timeout would fire SHALL win, giving DONE.
REQ-021 DONE: done=1, sbox_reset=0, sbox_enable_bar=1 (table held), chaos_reset=1; gen_count SHALL increment by 1 on entry, saturating at 255.
REQ-022 ERROR: error=1, with all other outputs as in IDLE; gen_count is unchanged.
REQ-023 busy SHALL be 1 in SEED, WARMUP and GENERATE, and 0 elsewhere; done and error SHALL never both be 1.
REQ-024 start SHALL be ignored while busy=1; in DONE or ERROR, start SHALL latch new seeds and enter SEED (rekey), clearing done or error on that edge.
REQ-025 abort high in any state other than IDLE SHALL move the FSM to IDLE on the next edge; abort SHALL take priority over start and sbox_ready.
REQ-026 chaos_x*_init SHALL change only on a start-accepting edge.
REQ-027 sbox_ready high outside GENERATE SHALL be ignored.

Reset
REQ-028 While reset is high: state=IDLE, counter=0, chaos_x*_init=0, gen_count=0, busy=done=error=0, chaos_reset=sbox_reset=sbox_enable_bar=1, independent of clk.
REQ-029 Reset asserted mid-session SHALL force the reset state immediately; after release, the FSM stays in IDLE until the next start.

Verification (WARMUP=4, TIMEOUT=16)
REQ-030 Start with seeds 3DCCCD53/3C23D70A/00000000 -> 1 cycle SEED, 4 cycles WARMUP, then GENERATE; sbox_ready after 10 cycles -> done=1 on the next edge, gen_count=1, chaos_x1_init=3DCCCD53.
REQ-031 Start with sbox_ready never asserted -> error=1 after exactly 16 GENERATE cycles, gen_count=0; a fresh start then re-enters SEED and error=0.
REQ-032 sbox_ready on the 16th GENERATE cycle -> done=1, error=0.
REQ-033 Abort during WARMUP cycle 2, with start also high -> IDLE next edge, busy=0, seeds unchanged; start pulses during busy are ignored.
REQ-034 Asynchronous reset mid-GENERATE, between clock edges -> all outputs at reset values immediately; 256 successful sessions -> gen_count=255.
REQ-035 WARMUP=0 build -> SEED goes directly to GENERATE on the next edge.
